// File: rtl/proc_pkg.sv
// Shared definitions for the 8-bit processor: program memory geometry and
// the byte-stream loader's state encoding.
package proc_pkg;

    localparam int PROG_ADDR_W = 8;
    localparam int INST_W      = 16;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        LD_IDLE = 3'd0,
        LD_ADDR = 3'd1,
        LD_LEN  = 3'd2,
        LD_HI   = 3'd3,
        LD_LO   = 3'd4,
        LD_WR   = 3'd5,
        LD_CHK  = 3'd6,
        LD_FIN  = 3'd7
    } ld_state_e;

    // Link is stalled only while a word is being written or the frame is closing.
    function automatic logic ld_accepts(input ld_state_e s);
        return !(s == LD_WR || s == LD_FIN);
    endfunction

endpackage

// File: rtl/prog_loader.sv
// Byte-stream program loader: unpacks SYNC/ADDR/LEN/{HI,LO}*/CHK frames into
// 16-bit instruction memory writes and holds the CPU off while a frame is open.
module prog_loader
    import proc_pkg::*;
#(
    parameter int         ADDR_W = PROG_ADDR_W,
    parameter int         DATA_W = INST_W,
    parameter logic [7:0] SYNC   = SYNC_BYTE
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        chk_q, chk_d;
    logic              in_ready_q, in_ready_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              xfer;

    assign xfer = in_valid & in_ready_q;

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LD_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            hi_q        <= '0;
            chk_q       <= '0;
            in_ready_q  <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            chk_q       <= chk_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            done_q      <= done_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LD_IDLE: if (xfer && in_data == SYNC) state_d = LD_ADDR;
            LD_ADDR: if (xfer) state_d = LD_LEN;
            LD_LEN:  if (xfer) state_d = (in_data == 8'd0) ? LD_CHK : LD_HI;
            LD_HI:   if (xfer) state_d = LD_LO;
            LD_LO:   if (xfer) state_d = LD_WR;
            LD_WR:   state_d = (cnt_q == 8'd1) ? LD_CHK : LD_HI;
            LD_CHK:  if (xfer) state_d = LD_FIN;
            LD_FIN:  state_d = LD_IDLE;
            default: state_d = LD_IDLE;
        endcase
    end

    // Outputs are computed one cycle early so every port comes from a flop;
    // mem_we/done therefore track state_d entering WR/FIN.
    always_comb begin
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        chk_d       = chk_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        done_d      = 1'b0;
        error_d     = error_q;
        in_ready_d  = ld_accepts(state_d);
        unique case (state_q)
            LD_IDLE: begin
                if (xfer && in_data == SYNC) begin
                    cpu_hold_d = 1'b1;
                    error_d    = 1'b0;
                    chk_d      = 8'd0;
                end
            end
            LD_ADDR: begin
                if (xfer) begin
                    addr_d = ADDR_W'(in_data);
                    chk_d  = chk_q ^ in_data;
                end
            end
            LD_LEN: begin
                if (xfer) begin
                    cnt_d = in_data;
                    chk_d = chk_q ^ in_data;
                end
            end
            LD_HI: begin
                if (xfer) begin
                    hi_d  = in_data;
                    chk_d = chk_q ^ in_data;
                end
            end
            LD_LO: begin
                if (xfer) begin
                    chk_d       = chk_q ^ in_data;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q;
                    mem_wdata_d = DATA_W'({hi_q, in_data});
                end
            end
            LD_WR: begin
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - 8'd1;
            end
            LD_CHK: begin
                if (xfer) begin
                    done_d = 1'b1;
                    if (in_data != chk_q) error_d = 1'b1;
                end
            end
            LD_FIN: cpu_hold_d = 1'b0;
            default: ;
        endcase
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign done      = done_q;
    assign error     = error_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: framed byte streams with hand-computed
// writes, checksum outcomes, hold/ready timing and mid-frame reset.
module tb_prog_loader;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    prog_loader dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Passive monitor, sampled mid-cycle.
    logic [7:0]  wa[$];
    logic [15:0] wd[$];
    int n_done = 0, n_hold = 0, n_rdy_lo = 0, n_rdy_bad = 0, n_hold_bad = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we) begin
                wa.push_back(mem_addr);
                wd.push_back(mem_wdata);
            end
            if (done) n_done++;
            if (cpu_hold) n_hold++;
            if (!in_ready) begin
                n_rdy_lo++;
                if (!(mem_we || done)) n_rdy_bad++;
            end
            if (prev_done && cpu_hold) n_hold_bad++;
            prev_done = done;
        end else begin
            prev_done = 1'b0;
        end
    end

    task automatic send(input logic [7:0] b, input int gap);
        int n;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_seq(input bq_t s, input bit gaps);
        foreach (s[i]) send(s[i], gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic chk_frame1(input string tag, input int base);
        chk({tag, "_nwr"}, 32'(wa.size() - base), 32'd2);
        if (wa.size() >= base + 2) begin
            chk({tag, "_a0"}, 32'(wa[base]),     32'h10);
            chk({tag, "_d0"}, 32'(wd[base]),     32'h8005);
            chk({tag, "_a1"}, 32'(wa[base + 1]), 32'h11);
            chk({tag, "_d1"}, 32'(wd[base + 1]), 32'h0012);
        end
    endtask

    bq_t fr1, fr2, fr3;
    int  b_wr, b_done, b_hold, b_rdy;

    initial begin
        fr1 = '{8'hA5, 8'h10, 8'h02, 8'h80, 8'h05, 8'h00, 8'h12, 8'h85};
        fr2 = '{8'hA5, 8'hFF, 8'h02, 8'hC0, 8'h00, 8'hC0, 8'h00, 8'hFD};
        fr3 = '{8'hA5, 8'h10, 8'h02, 8'h80, 8'h05, 8'h00, 8'h12, 8'h84};
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        #12;
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we",    32'(mem_we),   32'd0);
        chk("rst_addr",  32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd0);
        chk("rst_done",  32'(done),     32'd0);
        chk("rst_err",   32'(error),    32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // 1: normal frame, back-to-back bytes
        b_wr = wa.size(); b_done = n_done; b_hold = n_hold; b_rdy = n_rdy_lo;
        send_seq(fr1, 1'b0);
        idle(4);
        chk_frame1("t1", b_wr);
        chk("t1_done",  32'(n_done - b_done), 32'd1);
        chk("t1_err",   32'(error), 32'd0);
        chk("t1_hold",  32'(n_hold - b_hold), 32'd10);
        chk("t1_rdylo", 32'(n_rdy_lo - b_rdy), 32'd3);

        // 2: address wrap
        b_wr = wa.size(); b_done = n_done;
        send_seq(fr2, 1'b0);
        idle(4);
        chk("t2_nwr", 32'(wa.size() - b_wr), 32'd2);
        if (wa.size() >= b_wr + 2) begin
            chk("t2_a0", 32'(wa[b_wr]),     32'hFF);
            chk("t2_d0", 32'(wd[b_wr]),     32'hC000);
            chk("t2_a1", 32'(wa[b_wr + 1]), 32'h00);
            chk("t2_d1", 32'(wd[b_wr + 1]), 32'hC000);
        end
        chk("t2_done", 32'(n_done - b_done), 32'd1);
        chk("t2_err",  32'(error), 32'd0);

        // 3: bad checksum, error sticky until next SYNC
        b_wr = wa.size(); b_done = n_done;
        send_seq(fr3, 1'b0);
        idle(4);
        chk_frame1("t3", b_wr);
        chk("t3_done", 32'(n_done - b_done), 32'd1);
        chk("t3_err",  32'(error), 32'd1);
        idle(5);
        chk("t3_err_sticky", 32'(error), 32'd1);

        // 4: junk dropped, then zero-length frame
        b_wr = wa.size(); b_done = n_done;
        send_seq('{8'h00, 8'hFF, 8'h33}, 1'b0);
        chk("t4_junk_err",  32'(error),    32'd1);
        chk("t4_junk_hold", 32'(cpu_hold), 32'd0);
        send(8'hA5, 0);
        chk("t4_sync_err",  32'(error),    32'd0);
        chk("t4_sync_hold", 32'(cpu_hold), 32'd1);
        send_seq('{8'h20, 8'h00, 8'h20}, 1'b0);
        idle(4);
        chk("t4_nwr",  32'(wa.size() - b_wr), 32'd0);
        chk("t4_done", 32'(n_done - b_done),  32'd1);
        chk("t4_err",  32'(error), 32'd0);
        chk("t4_hold", 32'(cpu_hold), 32'd0);

        // 5: random idle gaps between bytes
        b_wr = wa.size(); b_done = n_done; b_rdy = n_rdy_lo;
        send_seq(fr1, 1'b1);
        idle(4);
        chk_frame1("t5", b_wr);
        chk("t5_done",  32'(n_done - b_done), 32'd1);
        chk("t5_err",   32'(error), 32'd0);
        chk("t5_rdylo", 32'(n_rdy_lo - b_rdy), 32'd3);

        // 6: reset in the middle of a frame
        b_wr = wa.size(); b_done = n_done;
        send_seq('{8'hA5, 8'h10, 8'h02, 8'h80}, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("t6_hold",  32'(cpu_hold), 32'd0);
        chk("t6_ready", 32'(in_ready), 32'd1);
        chk("t6_we",    32'(mem_we),   32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(3);
        chk("t6_nwr",  32'(wa.size() - b_wr), 32'd0);
        chk("t6_done", 32'(n_done - b_done),  32'd0);
        b_wr = wa.size();
        send_seq(fr1, 1'b0);
        idle(4);
        chk_frame1("t6", b_wr);
        chk("t6_err", 32'(error), 32'd0);

        chk("ready_low_only_wr_fin", 32'(n_rdy_bad),  32'd0);
        chk("hold_drop_after_done",  32'(n_hold_bad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
